// File: rtl/pipe_ctrl.sv
// Stall/flush/halt sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// Freezes on data-memory wait, flushes on taken branches, inserts load-use bubbles and drains on halt.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memRd_EX,
    input  logic             wrRegEn_EX,
    input  logic [3:0]       wrReg_EX,
    input  logic [3:0]       rdReg1_ID,
    input  logic [3:0]       rdReg2_ID,
    input  logic             useReg1_ID,
    input  logic             useReg2_ID,
    input  logic             PCSrc_MEM,
    input  logic             hlt_ID,
    input  logic             memBusy,
    output logic             pc_en,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use_s;

    // Load-use hazard: the load result is not forwardable to the instruction in ID yet.
    always_comb begin
        load_use_s = memRd_EX & wrRegEn_EX & (wrReg_EX != 4'd0) &
                     ((useReg1_ID & (rdReg1_ID == wrReg_EX)) |
                      (useReg2_ID & (rdReg2_ID == wrReg_EX)));
    end

    // Next-state and control outputs; priority memBusy > PCSrc_MEM > load-use > hlt_ID.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pc_en        = 1'b1;
        IF_ID_EN     = 1'b1;
        ID_EX_EN     = 1'b1;
        EX_MEM_EN    = 1'b1;
        MEM_WB_EN    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (memBusy) begin
                    pc_en     = 1'b0;
                    IF_ID_EN  = 1'b0;
                    ID_EX_EN  = 1'b0;
                    EX_MEM_EN = 1'b0;
                    MEM_WB_EN = 1'b0;
                end else if (PCSrc_MEM) begin
                    // A taken branch also cancels a wrong-path halt that is draining.
                    flush_IF_ID  = 1'b1;
                    flush_ID_EX  = 1'b1;
                    flush_EX_MEM = 1'b1;
                    state_d      = ST_RUN;
                    drain_d      = {DW{1'b0}};
                end else if (state_q == ST_DRAIN) begin
                    pc_en       = 1'b0;
                    flush_IF_ID = 1'b1;
                    if (drain_q == {DW{1'b0}}) begin
                        state_d = ST_HALT;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end else if (load_use_s) begin
                    pc_en       = 1'b0;
                    IF_ID_EN    = 1'b0;
                    flush_ID_EX = 1'b1;
                end else if (hlt_ID) begin
                    pc_en       = 1'b0;
                    flush_IF_ID = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_d     = DRAIN_INIT;
                end else begin
                    pc_en = 1'b1;
                end
            end
            default: begin
                pc_en     = 1'b0;
                IF_ID_EN  = 1'b0;
                ID_EX_EN  = 1'b0;
                EX_MEM_EN = 1'b0;
                MEM_WB_EN = 1'b0;
                state_d   = ST_HALT;
            end
        endcase
    end

    // Halted flag and saturating count of non-halted cycles with the PC held.
    always_comb begin
        halted_d = (state_d == ST_HALT);
        if ((pc_en == 1'b0) && (state_q != ST_HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, drain counter, halted flag and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_q     <= {DW{1'b0}};
            halted_q    <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised + directed bench for pipe_ctrl against a behavioural model of the
// stall/flush/halt rules; a second instance with a 3-bit counter exercises saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       memRd_EX, wrRegEn_EX, useReg1_ID, useReg2_ID, PCSrc_MEM, hlt_ID, memBusy;
    logic [3:0] wrReg_EX, rdReg1_ID, rdReg2_ID;

    logic        pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid, s_idex, s_exmem, s_memwb, s_f1, s_f2, s_f3, s_halted;
    logic [2:0]  s_stall_cnt;

    pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .memRd_EX(memRd_EX), .wrRegEn_EX(wrRegEn_EX),
        .wrReg_EX(wrReg_EX), .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID),
        .useReg1_ID(useReg1_ID), .useReg2_ID(useReg2_ID), .PCSrc_MEM(PCSrc_MEM),
        .hlt_ID(hlt_ID), .memBusy(memBusy), .pc_en(pc_en), .IF_ID_EN(IF_ID_EN),
        .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .memRd_EX(memRd_EX), .wrRegEn_EX(wrRegEn_EX),
        .wrReg_EX(wrReg_EX), .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID),
        .useReg1_ID(useReg1_ID), .useReg2_ID(useReg2_ID), .PCSrc_MEM(PCSrc_MEM),
        .hlt_ID(hlt_ID), .memBusy(memBusy), .pc_en(s_pc_en), .IF_ID_EN(s_ifid),
        .ID_EX_EN(s_idex), .EX_MEM_EN(s_exmem), .MEM_WB_EN(s_memwb),
        .flush_IF_ID(s_f1), .flush_ID_EX(s_f2), .flush_EX_MEM(s_f3),
        .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: draining flag, drain cycles still to go, halted flag, stall counters.
    bit m_drain, m_halted;
    int m_left, m_cnt, m_cnt_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        return memRd_EX && wrRegEn_EX && (wrReg_EX != 4'd0) &&
               ((useReg1_ID && rdReg1_ID == wrReg_EX) || (useReg2_ID && rdReg2_ID == wrReg_EX));
    endfunction

    // {pc_en, IF_ID, ID_EX, EX_MEM, MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted}
    function automatic logic [8:0] expect_out();
        if (m_halted)       return 9'b0_0000_000_1;
        else if (memBusy)   return 9'b0_0000_000_0;
        else if (PCSrc_MEM) return 9'b1_1111_111_0;
        else if (m_drain)   return 9'b0_1111_100_0;
        else if (load_use()) return 9'b0_0111_010_0;
        else if (hlt_ID)    return 9'b0_1111_100_0;
        else                return 9'b1_1111_000_0;
    endfunction

    task automatic compare();
        logic [8:0] act, act_s;
        act   = {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
                 flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted};
        act_s = {s_pc_en, s_ifid, s_idex, s_exmem, s_memwb, s_f1, s_f2, s_f3, s_halted};
        chk("ctrl", {23'd0, act}, {23'd0, expect_out()});
        chk("ctrl_small", {23'd0, act_s}, {23'd0, expect_out()});
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        chk("stall_cnt_small", {29'd0, s_stall_cnt}, m_cnt_s);
    endtask

    task automatic model_reset();
        m_drain = 0; m_halted = 0; m_left = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic clr_in();
        memRd_EX = 0; wrRegEn_EX = 0; wrReg_EX = 4'd0; rdReg1_ID = 4'd0; rdReg2_ID = 4'd0;
        useReg1_ID = 0; useReg2_ID = 0; PCSrc_MEM = 0; hlt_ID = 0; memBusy = 0;
    endtask

    // Called at a negedge: check, let one clock edge pass, advance the model.
    task automatic step();
        logic [8:0] e;
        bit lu;
        #2;
        compare();
        e  = expect_out();
        lu = load_use();
        @(posedge clk);
        if (!m_halted && !e[8]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 7) m_cnt_s++;
        end
        if (!m_halted && !memBusy) begin
            if (PCSrc_MEM) begin
                m_drain = 0; m_left = 0;
            end else if (m_drain) begin
                if (m_left == 0) begin
                    m_drain = 0; m_halted = 1;
                end else begin
                    m_left--;
                end
            end else if (!lu && hlt_ID) begin
                m_drain = 1; m_left = 3;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        model_reset();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        clr_in();
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle run
        for (int i = 0; i < 10; i++) step();
        chk("idle_cnt_lit", {16'd0, stall_cnt}, 32'd0);

        // Load-use via rdReg2, then same with r0 destination
        memRd_EX = 1; wrRegEn_EX = 1; wrReg_EX = 4'd3; rdReg2_ID = 4'd3; useReg2_ID = 1;
        #1 chk("lu_pc_en_lit", {31'd0, pc_en}, 32'd0);
        #0 step();
        clr_in();
        step();
        chk("lu_cnt_lit", {16'd0, stall_cnt}, 32'd1);
        memRd_EX = 1; wrRegEn_EX = 1; wrReg_EX = 4'd0; rdReg2_ID = 4'd0; useReg2_ID = 1;
        step();
        clr_in();
        chk("r0_cnt_lit", {16'd0, stall_cnt}, 32'd1);

        // Branch flush pulse
        PCSrc_MEM = 1; step(); clr_in(); step();
        chk("br_cnt_lit", {16'd0, stall_cnt}, 32'd1);

        // Halt drain: halted after 4 drain cycles
        do_reset();
        hlt_ID = 1; step(); clr_in();
        n = 0;
        while (!halted && n < 20) begin step(); n++; end
        chk("drain_len_lit", n, 32'd4);
        for (int i = 0; i < 3; i++) step();
        chk("halt_cnt_lit", {16'd0, stall_cnt}, 32'd5);

        // Branch during drain cycle 2 cancels halt
        do_reset();
        hlt_ID = 1; step(); clr_in();
        step();
        PCSrc_MEM = 1; step(); clr_in();
        for (int i = 0; i < 8; i++) step();
        chk("cancel_halted_lit", {31'd0, halted}, 32'd0);
        chk("cancel_cnt_lit", {16'd0, stall_cnt}, 32'd2);

        // memBusy for 3 cycles mid-drain stretches the drain
        do_reset();
        hlt_ID = 1; step(); clr_in();
        step(); n = 1;
        memBusy = 1;
        for (int i = 0; i < 3; i++) begin step(); n++; end
        memBusy = 0;
        while (!halted && n < 30) begin step(); n++; end
        chk("busy_drain_len_lit", n, 32'd7);
        chk("busy_cnt_lit", {16'd0, stall_cnt}, 32'd8);
        chk("small_sat_lit", {29'd0, s_stall_cnt}, 32'd7);

        // Load-use coinciding with branch: flush only
        do_reset();
        memRd_EX = 1; wrRegEn_EX = 1; wrReg_EX = 4'd5; rdReg1_ID = 4'd5; useReg1_ID = 1;
        PCSrc_MEM = 1;
        #1 chk("lu_br_pc_en_lit", {31'd0, pc_en}, 32'd1);
        #0 step();
        clr_in();

        // Saturation of the small counter on a long freeze, then reset mid-drain
        memBusy = 1;
        for (int i = 0; i < 10; i++) step();
        memBusy = 0;
        hlt_ID = 1; step(); clr_in();
        step(); step();
        do_reset();
        chk("rst_halted_lit", {31'd0, halted}, 32'd0);
        chk("rst_cnt_lit", {16'd0, stall_cnt}, 32'd0);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && $urandom_range(0, 99) < 20) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end
            memBusy    = ($urandom_range(0, 99) < 15);
            PCSrc_MEM  = ($urandom_range(0, 99) < 10);
            hlt_ID     = ($urandom_range(0, 99) < 4);
            memRd_EX   = ($urandom_range(0, 99) < 40);
            wrRegEn_EX = ($urandom_range(0, 99) < 80);
            wrReg_EX   = 4'($urandom_range(0, 3));
            rdReg1_ID  = 4'($urandom_range(0, 3));
            rdReg2_ID  = 4'($urandom_range(0, 3));
            useReg1_ID = 1'($urandom_range(0, 1));
            useReg2_ID = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
